data_mem_ext: RTL and testbench

DATA_MEM_EXT -- requirements
Module: data_mem_ext

---
 rtl/data_mem_pkg.sv | 12 +
 rtl/data_mem_clr.sv | 56 +++++
 rtl/data_mem_ext.sv | 92 +++++++++
 tb/tb_data_mem_ext.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared types and default sizes for the data_mem_ext word memory.
package data_mem_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ADDR_W = 8;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

endpackage

// File: rtl/data_mem_clr.sv
// Clear sequencer: zeroes one word per cycle from address 0 upward after reset,
// then parks in READY. Only instantiated when DATA_MEM_EXT_CLEAR_EN is defined.
module data_mem_clr
    import data_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              clr_we_c
);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic              busy_nxt;
    logic              done_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= CLEAR;
            clr_addr <= '0;
            busy     <= 1'b1;
        end else begin
            state    <= state_nxt;
            clr_addr <= addr_nxt;
            busy     <= busy_nxt;
        end
    end

    // done marks the cycle that writes the top address; READY follows on the next edge
    always_comb begin
        state_nxt = state;
        addr_nxt  = clr_addr;
        clr_we_c  = 1'b0;
        done_c    = 1'b0;
        case (state)
            CLEAR: begin
                clr_we_c = 1'b1;
                done_c   = (clr_addr == {ADDR_W{1'b1}});
                addr_nxt = ADDR_W'(clr_addr + 1'b1);
                if (done_c) begin
                    state_nxt = READY;
                    addr_nxt  = '0;
                end
            end
            READY: begin
                state_nxt = READY;
            end
        endcase
        busy_nxt = (state_nxt == CLEAR);
    end

endmodule

// File: rtl/data_mem_ext.sv
// Byte-enabled single-port word memory with registered read (latency 1, write-first).
// Optional power-up clear sequencer enabled by defining DATA_MEM_EXT_CLEAR_EN.
module data_mem_ext
    import data_mem_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                dwe,
    input  logic [DATA_W/8-1:0] be,
    input  logic                re,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata,
    output logic                rvalid,
    output logic                busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned NB    = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              rd_en_c;
    logic              wr_en_c;
    logic [ADDR_W-1:0] wr_addr_c;
    logic [DATA_W-1:0] wr_data_c;
    logic [DATA_W-1:0] merged_c;

`ifdef DATA_MEM_EXT_CLEAR_EN
    logic [ADDR_W-1:0] clr_addr;
    logic              clr_we_c;

    data_mem_clr #(
        .ADDR_W (ADDR_W)
    ) u_clr (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy),
        .clr_addr (clr_addr),
        .clr_we_c (clr_we_c)
    );
`else
    assign busy = 1'b0;
`endif

    // Old word with enabled bytes replaced; also the write-first read value
    always_comb begin
        merged_c = mem[addr];
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                merged_c[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        rd_en_c   = re && !busy;
        wr_en_c   = dwe && !busy;
        wr_addr_c = addr;
        wr_data_c = merged_c;
`ifdef DATA_MEM_EXT_CLEAR_EN
        if (clr_we_c) begin
            wr_en_c   = 1'b1;
            wr_addr_c = clr_addr;
            wr_data_c = '0;
        end
`endif
    end

    // Array has no reset; zeroing is the clear sequencer's job
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_addr_c] <= wr_data_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= rd_en_c;
            if (rd_en_c) begin
                rdata <= dwe ? merged_c : mem[addr];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ext.sv
// Directed self-checking bench for data_mem_ext; clear-sequencer scenarios run
// only when DATA_MEM_EXT_CLEAR_EN is defined.
module tb_data_mem_ext;

    logic        clk;
    logic        rst;
    logic        dwe;
    logic [1:0]  be;
    logic        re;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        rvalid;
    logic        busy;

    int checks;
    int errors;

    data_mem_ext dut (
        .clk    (clk),
        .rst    (rst),
        .dwe    (dwe),
        .be     (be),
        .re     (re),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .rvalid (rvalid),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wr(input logic [7:0] a, input logic [15:0] d, input logic [1:0] b);
        dwe = 1'b1; addr = a; wdata = d; be = b;
        @(negedge clk);
        dwe = 1'b0; be = 2'b00;
    endtask

    task automatic rd(input logic [7:0] a);
        re = 1'b1; addr = a;
        @(negedge clk);
        re = 1'b0;
    endtask

    // Counts cycles with busy high after release; returns count (bounded)
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic release_reset();
        int n;
        @(negedge clk);
        rst = 1'b0;
`ifdef DATA_MEM_EXT_CLEAR_EN
        count_busy(n);
        checks++;
        if (n !== 256) begin
            errors++;
            $display("FAIL clear_len: got %0d cycles, expected 256", n);
        end
`else
        n = 0;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; dwe = 0; re = 0; be = 0; addr = 0; wdata = 0;
        #1;
        checks++;
        if (rdata !== 16'h0000 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: rdata=%h rvalid=%b, expected 0000/0", rdata, rvalid);
        end
        @(negedge clk);
        @(negedge clk);
`ifdef DATA_MEM_EXT_CLEAR_EN
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_busy: busy=%b, expected 1", busy);
        end
`endif
        release_reset();
        checks++;
        if (busy !== 1'b0 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL ready_idle: busy=%b rvalid=%b, expected 0/0", busy, rvalid);
        end
    endtask

`ifdef DATA_MEM_EXT_CLEAR_EN
    task automatic test_clear_contents();
        rd(8'h00);
        checks++;
        if (rvalid !== 1'b1 || rdata !== 16'h0000) begin
            errors++;
            $display("FAIL clr_rd00: rvalid=%b rdata=%h, expected 1/0000", rvalid, rdata);
        end
        rd(8'hFF);
        checks++;
        if (rvalid !== 1'b1 || rdata !== 16'h0000) begin
            errors++;
            $display("FAIL clr_rdFF: rvalid=%b rdata=%h, expected 1/0000", rvalid, rdata);
        end
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b0) begin
            errors++;
            $display("FAIL clr_pulse: rvalid=%b, expected 0", rvalid);
        end
    endtask

    task automatic test_busy_ignore();
        int n;
        wr(8'h20, 16'h4242, 2'b11);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        dwe = 1'b1; re = 1'b1; addr = 8'h80; wdata = 16'hFFFF; be = 2'b11;
        @(negedge clk);
        dwe = 1'b0; re = 1'b0; be = 2'b00;
        checks++;
        if (rvalid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_ignore_rv: rvalid=%b busy=%b, expected 0/1", rvalid, busy);
        end
        // Address 0x10 is already cleared here, so a leaked write would persist
        repeat (140) @(negedge clk);
        wr(8'h10, 16'hDEAD, 2'b11);
        count_busy(n);
        rd(8'h80);
        checks++;
        if (rvalid !== 1'b1 || rdata !== 16'h0000) begin
            errors++;
            $display("FAIL busy_ignore_80: rvalid=%b rdata=%h, expected 1/0000", rvalid, rdata);
        end
        rd(8'h10);
        checks++;
        if (rdata !== 16'h0000) begin
            errors++;
            $display("FAIL busy_ignore_10: rdata=%h, expected 0000", rdata);
        end
        rd(8'h20);
        checks++;
        if (rdata !== 16'h0000) begin
            errors++;
            $display("FAIL clr_old_data: rdata=%h, expected 0000", rdata);
        end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        wr(8'h00, 16'h5A5A, 2'b11);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        count_busy(n);
        checks++;
        if (n !== 256) begin
            errors++;
            $display("FAIL mid_clear_len: got %0d cycles, expected 256", n);
        end
        rd(8'h00);
        checks++;
        if (rvalid !== 1'b1 || rdata !== 16'h0000) begin
            errors++;
            $display("FAIL mid_clear_rd00: rvalid=%b rdata=%h, expected 1/0000", rvalid, rdata);
        end
    endtask
`endif

    task automatic test_write_read();
        wr(8'h05, 16'h3C3C, 2'b11);
        rd(8'h05);
        checks++;
        if (rvalid !== 1'b1 || rdata !== 16'h3C3C) begin
            errors++;
            $display("FAIL wr_rd05: rvalid=%b rdata=%h, expected 1/3c3c", rvalid, rdata);
        end
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b0 || rdata !== 16'h3C3C) begin
            errors++;
            $display("FAIL rd_hold: rvalid=%b rdata=%h, expected 0/3c3c", rvalid, rdata);
        end
    endtask

    task automatic test_byte_enable();
        wr(8'h10, 16'hA5C3, 2'b11);
        rd(8'h10);
        checks++;
        if (rdata !== 16'hA5C3) begin
            errors++;
            $display("FAIL be_full: rdata=%h, expected a5c3", rdata);
        end
        dwe = 1'b1; re = 1'b1; addr = 8'h10; wdata = 16'h1177; be = 2'b01;
        @(negedge clk);
        dwe = 1'b0; re = 1'b0; be = 2'b00;
        checks++;
        if (rvalid !== 1'b1 || rdata !== 16'hA577) begin
            errors++;
            $display("FAIL write_first: rvalid=%b rdata=%h, expected 1/a577", rvalid, rdata);
        end
        rd(8'h10);
        checks++;
        if (rdata !== 16'hA577) begin
            errors++;
            $display("FAIL be_low_stored: rdata=%h, expected a577", rdata);
        end
        wr(8'h10, 16'h12FF, 2'b10);
        rd(8'h10);
        checks++;
        if (rdata !== 16'h1277) begin
            errors++;
            $display("FAIL be_high: rdata=%h, expected 1277", rdata);
        end
        wr(8'h10, 16'hFFFF, 2'b00);
        rd(8'h10);
        checks++;
        if (rdata !== 16'h1277) begin
            errors++;
            $display("FAIL be_none: rdata=%h, expected 1277", rdata);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp [4];
        exp[0] = 16'h0102; exp[1] = 16'hF00D; exp[2] = 16'h8001; exp[3] = 16'h7E7E;
        for (int i = 0; i < 4; i++) begin
            wr(8'h40 + 8'(i), exp[i], 2'b11);
        end
        re = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr = 8'h40 + 8'(i);
            @(negedge clk);
            checks++;
            if (rvalid !== 1'b1 || rdata !== exp[i]) begin
                errors++;
                $display("FAIL b2b_%0d: rvalid=%b rdata=%h, expected 1/%h", i, rvalid, rdata, exp[i]);
            end
        end
        re = 1'b0;
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: rvalid=%b, expected 0", rvalid);
        end
    endtask

    task automatic test_reset_inflight();
        re = 1'b1; addr = 8'h05;
        @(posedge clk);
        #1;
        re = 1'b0;
        checks++;
        if (rvalid !== 1'b1 || rdata !== 16'h3C3C) begin
            errors++;
            $display("FAIL inflight_pre: rvalid=%b rdata=%h, expected 1/3c3c", rvalid, rdata);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (rvalid !== 1'b0 || rdata !== 16'h0000) begin
            errors++;
            $display("FAIL async_rst: rvalid=%b rdata=%h, expected 0/0000", rvalid, rdata);
        end
        release_reset();
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (rvalid !== 1'b0) begin
                errors++;
                $display("FAIL inflight_drop: rvalid=%b, expected 0", rvalid);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
`ifdef DATA_MEM_EXT_CLEAR_EN
        test_clear_contents();
`endif
        test_write_read();
        test_byte_enable();
        test_back_to_back();
        test_reset_inflight();
`ifdef DATA_MEM_EXT_CLEAR_EN
        test_busy_ignore();
        test_reset_mid_clear();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
